// File: rtl/serializer_pkg.sv
// Definitions shared by the serializer arbiter slice: the FSM state
// encoding and the default serializer address width.
package serializer_pkg;
    localparam int SER_ADDRW = 24;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        DONE
    } state_t;
endpackage

// File: rtl/serializer_arbiter_rr.sv
// Combinational round-robin pick. The scan starts one past the pointer, so the
// requester served most recently gets the lowest priority.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    logic [IW-1:0] w_cand;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_grant[w_cand]  = 1'b1;
                o_idx            = w_cand;
            end
        end
        o_any = w_found;
    end
endmodule

// File: rtl/serializer_arbiter.sv
// Shares one SPI serializer between NREQ requesters: round-robin grant,
// request handshake, completion/timeout tracking and a per-owner response pulse.
module serializer_arbiter
    import serializer_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADDRW   = SER_ADDRW,
    parameter int TIMEOUT = 1024,
    parameter int TCNTW   = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*ADDRW-1:0]   req_addr,
    output logic [NREQ-1:0]         req_ack,
    output logic [NREQ-1:0]         rsp_valid,
    output logic                    rsp_err,
    output logic                    ser_valid,
    output logic [ADDRW-1:0]        ser_addr,
    input  logic                    ser_ready,
    input  logic                    ser_err,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    timeout_flag
);
    localparam int               GIDW   = $clog2(NREQ);
    localparam bit               TEN    = (TIMEOUT != 0);
    localparam logic [TCNTW-1:0] TLIMIT = TEN ? TCNTW'(TIMEOUT - 1) : '0;

    state_t           r_state, w_next_state;
    logic [TCNTW-1:0] r_timer;
    logic [GIDW-1:0]  r_ptr, r_grant, w_idx;
    logic [ADDRW-1:0] r_addr, w_sel_addr;
    logic [NREQ-1:0]  r_ack, w_onehot;
    logic             r_err, r_seen_low, r_tflag;
    logic             w_any, w_tmo_hit, w_complete;

    rr_arbiter #(.N(NREQ), .IW(GIDW)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_onehot),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_tmo_hit  = TEN && (r_timer == TLIMIT);
    assign w_complete = r_seen_low && ser_ready;

    // Acceptance and completion take priority over a timeout landing in the same cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (w_any) w_next_state = ISSUE;
            ISSUE: begin
                if (ser_ready)      w_next_state = BUSY;
                else if (w_tmo_hit) w_next_state = DONE;
            end
            BUSY:  if (w_complete || w_tmo_hit) w_next_state = DONE;
            DONE:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_onehot[i]) w_sel_addr = req_addr[i*ADDRW +: ADDRW];
        end
        rsp_valid = '0;
        if (r_state == DONE) rsp_valid[r_grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_ptr      <= GIDW'(NREQ - 1);
            r_grant    <= '0;
            r_addr     <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_seen_low <= 1'b0;
            r_tflag    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ack   <= '0;
            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    r_err   <= 1'b0;
                    if (w_any) begin
                        r_addr  <= w_sel_addr;
                        r_grant <= w_idx;
                        r_ack   <= w_onehot;
                    end
                end
                ISSUE: begin
                    if (ser_ready) begin
                        r_timer    <= '0;
                        r_seen_low <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_tflag <= 1'b1;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                BUSY: begin
                    if (w_complete) begin
                        r_err <= ser_err;
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_tflag <= 1'b1;
                    end else begin
                        if (r_timer != '1) r_timer <= r_timer + 1'b1;
                        if (!ser_ready)    r_seen_low <= 1'b1;
                    end
                end
                DONE:    r_ptr <= r_grant;
                default: ;
            endcase
        end
    end

    assign req_ack      = r_ack;
    assign rsp_err      = (r_state == DONE) && r_err;
    assign ser_valid    = (r_state == ISSUE);
    assign ser_addr     = r_addr;
    assign busy         = (r_state != IDLE);
    assign grant_id     = r_grant;
    assign timeout_flag = r_tflag;
endmodule
